// File: rtl/rca_multiword_sequencer_pkg.sv
// Shared definitions for the multi-word ripple-carry sequencer: default slice
// geometry and the controller state encoding.
package rca_multiword_sequencer_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_M = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_multiword_sequencer_adder.sv
// N-bit ripple-carry adder: one full-adder cell per bit, carry rippling from
// bit 0 upward. This is the single arithmetic resource the sequencer shares.
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] w_carry;

    always_comb begin
        // NOTE: every output is assigned before the loop touches it, so no path can infer a latch.
        w_carry    = '0;
        sum        = '0;
        w_carry[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
        cout = w_carry[N];
    end

endmodule

// File: rtl/rca_multiword_sequencer.sv
// W=N*M-bit add/subtract performed LSB slice first over M cycles on one shared
// N-bit ripple_carry_adder, with a start/done handshake toward the requester.
module rca_multiword_sequencer
    import rca_multiword_sequencer_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int M = DEFAULT_M
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sub,
    input  logic [N*M-1:0] A,
    input  logic [N*M-1:0] B,
    output logic           busy,
    output logic           done,
    output logic [N*M-1:0] S,
    output logic           carry_out,
    output logic           overflow
);

    localparam int W  = N * M;
    localparam int IW = $clog2(M);

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic            r_creg;
    logic [W-1:0]    r_s;
    logic            r_carry_out;
    logic            r_overflow;

    logic [N-1:0]    w_a_slice;
    logic [N-1:0]    w_b_slice;
    logic [N-1:0]    w_sum;
    logic            w_cout;
    logic            w_accept;
    logic            w_last;

    // Subtraction is A + ~B + 1: B is inverted per slice and the +1 is the initial creg.
    assign w_a_slice = r_a[r_idx*N +: N];
    assign w_b_slice = r_b[r_idx*N +: N] ^ {N{r_sub}};
    assign w_last    = (r_idx == IW'(M - 1));

    ripple_carry_adder #(.N(N)) u_adder (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_creg),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_accept     = start;
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                busy         = 1'b1;
                w_state_next = w_last ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_accept     = start;
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_creg      <= 1'b0;
            r_s         <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a    <= A;
                r_b    <= B;
                r_sub  <= sub;
                r_idx  <= '0;
                r_creg <= sub;
            end else if (r_state == ST_RUN) begin
                r_s[r_idx*N +: N] <= w_sum;
                r_creg            <= w_cout;
                if (w_last) begin
                    r_idx       <= '0;
                    r_carry_out <= w_cout;
                    r_overflow  <= (w_a_slice[N-1] == w_b_slice[N-1]) &&
                                   (w_sum[N-1] != w_a_slice[N-1]);
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

    assign S         = r_s;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule
